// File: rtl/operand_fetch_unit.sv
// operand_fetch_unit: issues register-file reads, tracks busy registers, bypasses same-edge writeback
module operand_fetch_unit #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [4:0]      in_rd,
    input  logic            in_rd_we,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rs1_val,
    output logic [XLEN-1:0] out_rs2_val,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [4:0]      rf_r1,
    output logic [4:0]      rf_r2,
    output logic            rf_r_en,
    input  logic [XLEN-1:0] rf_r1_read,
    input  logic [XLEN-1:0] rf_r2_read,
    output logic [4:0]      rf_rd,
    output logic            rf_w_en,
    output logic [XLEN-1:0] rf_write_data,
    output logic [NREG-1:0] busy_vec
);
    localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, HOLD = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic            rd_we_q, rd_we_d, byp1_q, byp1_d, byp2_q, byp2_d;
    logic [XLEN-1:0] byp1_data_q, byp1_data_d, byp2_data_q, byp2_data_d;
    logic [XLEN-1:0] hold1_q, hold1_d, hold2_q, hold2_d;
    logic            hazard, in_fire, out_fire;
    logic [XLEN-1:0] live1, live2;

    assign rf_r1         = in_rs1;
    assign rf_r2         = in_rs2;
    assign rf_rd         = wb_rd;
    assign rf_w_en       = wb_en;
    assign rf_write_data = wb_data;
    assign busy_vec      = busy_q;

    always_comb begin
        // a writeback landing this cycle resolves the dependency through the bypass
        hazard   = (in_rs1 != 5'd0 && busy_q[in_rs1] && !(wb_en && wb_rd == in_rs1))
                || (in_rs2 != 5'd0 && busy_q[in_rs2] && !(wb_en && wb_rd == in_rs2))
                || (in_rd_we && in_rd != 5'd0 && busy_q[in_rd] && !(wb_en && wb_rd == in_rd));
        out_valid = state_q != IDLE;
        out_fire  = out_valid && out_ready;
        in_ready  = (state_q == IDLE || out_fire) && !hazard;
        in_fire   = in_valid && in_ready;
        rf_r_en   = in_fire;
        live1     = rs1_q == 5'd0 ? '0 : byp1_q ? byp1_data_q : rf_r1_read;
        live2     = rs2_q == 5'd0 ? '0 : byp2_q ? byp2_data_q : rf_r2_read;
        out_rs1_val = state_q == READ ? live1 : state_q == HOLD ? hold1_q : '0;
        out_rs2_val = state_q == READ ? live2 : state_q == HOLD ? hold2_q : '0;
        out_rd    = rd_q;
        out_rd_we = rd_we_q && out_valid;
        state_d   = in_fire ? READ : (state_q == IDLE || out_ready) ? IDLE : HOLD;
        rs1_d     = in_fire ? in_rs1 : rs1_q;
        rs2_d     = in_fire ? in_rs2 : rs2_q;
        rd_d      = in_fire ? in_rd : rd_q;
        rd_we_d   = in_fire ? in_rd_we : rd_we_q;
        byp1_d    = in_fire ? (wb_en && wb_rd == in_rs1 && in_rs1 != 5'd0) : byp1_q;
        byp2_d    = in_fire ? (wb_en && wb_rd == in_rs2 && in_rs2 != 5'd0) : byp2_q;
        byp1_data_d = in_fire ? wb_data : byp1_data_q;
        byp2_data_d = in_fire ? wb_data : byp2_data_q;
        hold1_d   = state_q == READ ? live1 : hold1_q;
        hold2_d   = state_q == READ ? live2 : hold2_q;
        busy_d    = busy_q;
        if (wb_en && wb_rd != 5'd0) busy_d[wb_rd] = 1'b0;
        if (in_fire && in_rd_we && in_rd != 5'd0) busy_d[in_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rd_we_q     <= 1'b0;
            byp1_q      <= 1'b0;
            byp2_q      <= 1'b0;
            byp1_data_q <= '0;
            byp2_data_q <= '0;
            hold1_q     <= '0;
            hold2_q     <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            rd_we_q     <= rd_we_d;
            byp1_q      <= byp1_d;
            byp2_q      <= byp2_d;
            byp1_data_q <= byp1_data_d;
            byp2_data_q <= byp2_data_d;
            hold1_q     <= hold1_d;
            hold2_q     <= hold2_d;
        end
    end
endmodule

// File: tb/tb_operand_fetch_unit.sv
// tb_operand_fetch_unit: directed checks with a scoreboard queue and a behavioural register file
module tb_operand_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, in_rd_we, out_valid, out_ready, out_rd_we;
    logic [4:0]  in_rs1, in_rs2, in_rd, out_rd, wb_rd, rf_r1, rf_r2, rf_rd;
    logic [31:0] out_rs1_val, out_rs2_val, wb_data, rf_r1_read, rf_r2_read, rf_write_data;
    logic        wb_en, rf_r_en, rf_w_en;
    logic [31:0] busy_vec;

    typedef struct packed {logic [31:0] a; logic [31:0] b; logic [4:0] rd; logic we;} exp_t;
    exp_t        sb[$];
    logic [31:0] regs [32];
    logic [31:0] model [32];
    int          tests = 0, fails = 0, fires = 0;

    operand_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
        .out_valid(out_valid), .out_ready(out_ready), .out_rs1_val(out_rs1_val),
        .out_rs2_val(out_rs2_val), .out_rd(out_rd), .out_rd_we(out_rd_we),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .rf_r1(rf_r1), .rf_r2(rf_r2),
        .rf_r_en(rf_r_en), .rf_r1_read(rf_r1_read), .rf_r2_read(rf_r2_read),
        .rf_rd(rf_rd), .rf_w_en(rf_w_en), .rf_write_data(rf_write_data), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    // synchronous register file: reads return the value from before a same-edge write
    always @(posedge clk) begin
        if (rf_w_en && rf_rd != 5'd0) regs[rf_rd] <= rf_write_data;
        if (rf_r_en) begin
            rf_r1_read <= rf_r1 == 5'd0 ? 32'd0 : regs[rf_r1];
            rf_r2_read <= rf_r2 == 5'd0 ? 32'd0 : regs[rf_r2];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            fires++;
            chk("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_rs1_val", out_rs1_val, e.a);
                chk("out_rs2_val", out_rs2_val, e.b);
                chk("out_rd", 32'(out_rd), 32'(e.rd));
                chk("out_rd_we", 32'(out_rd_we), 32'(e.we));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        wb_en = 1'b1; wb_rd = r; wb_data = d;
        if (r != 5'd0) model[r] = d;
        step();
        wb_en = 1'b0;
    endtask

    task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d, input logic we);
        exp_t e;
        in_valid = 1'b1; in_rs1 = r1; in_rs2 = r2; in_rd = d; in_rd_we = we;
        #1;
        chk("in_ready_issue", 32'(in_ready), 1);
        e.a = r1 == 5'd0 ? 32'd0 : model[r1];
        e.b = r2 == 5'd0 ? 32'd0 : model[r2];
        e.rd = d; e.we = we;
        sb.push_back(e);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] h1, h2;
        int f0;
        rst_n = 1'b0; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_we = 1'b0;
        out_ready = 1'b1; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        repeat (2) step();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy_vec", busy_vec, 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_rd_we", 32'(out_rd_we), 0);
        chk("rst_out_rs1_val", out_rs1_val, 0);
        rst_n = 1'b1;
        step();

        for (int i = 1; i <= 12; i++) wb(5'(i), i == 5 ? 32'h1234 : 32'h1000 + 32'(i));
        chk("wb_nonbusy_busy_vec", busy_vec, 0);

        issue(5'd5, 5'd0, 5'd0, 1'b0);
        chk("basic_out_rs1", out_rs1_val, 32'h1234);
        chk("basic_out_rs2", out_rs2_val, 32'h0);
        step();
        chk("basic_idle", 32'(out_valid), 0);

        // RAW: x7 busy until its writeback, which is bypassed on the issuing edge
        issue(5'd1, 5'd2, 5'd7, 1'b1);
        chk("raw_busy7", busy_vec, 32'h80);
        in_valid = 1'b1; in_rs1 = 5'd7; in_rs2 = 5'd0; in_rd = 5'd0; in_rd_we = 1'b0;
        #1;
        chk("raw_stall0", 32'(in_ready), 0);
        step();
        chk("raw_stall1", 32'(in_ready), 0);
        step();
        chk("raw_stall2", 32'(in_ready), 0);
        in_valid = 1'b0;
        wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'hCAFE;
        model[7] = 32'hCAFE;
        issue(5'd7, 5'd0, 5'd0, 1'b0);
        wb_en = 1'b0;
        chk("raw_byp_out", out_rs1_val, 32'hCAFE);
        chk("raw_busy_clr", busy_vec, 0);
        step();

        // WAW: second write to x8 waits for the first to retire
        issue(5'd1, 5'd1, 5'd8, 1'b1);
        in_valid = 1'b1; in_rs1 = 5'd3; in_rs2 = 5'd4; in_rd = 5'd8; in_rd_we = 1'b1;
        #1;
        chk("waw_stall", 32'(in_ready), 0);
        in_valid = 1'b0;
        wb(5'd8, 32'h8888);
        chk("waw_cleared", busy_vec, 0);

        // backpressure: outputs frozen while sources get rewritten
        out_ready = 1'b0;
        h1 = model[5]; h2 = model[6];
        issue(5'd5, 5'd6, 5'd4, 1'b0);
        wb(5'd5, 32'h5555);
        chk("bp_valid0", 32'(out_valid), 1);
        chk("bp_rs1_0", out_rs1_val, h1);
        wb(5'd6, 32'h6666);
        chk("bp_valid1", 32'(out_valid), 1);
        chk("bp_rs2_1", out_rs2_val, h2);
        step();
        chk("bp_rs1_2", out_rs1_val, h1);
        chk("bp_rs2_2", out_rs2_val, h2);
        chk("bp_rd_2", 32'(out_rd), 4);
        out_ready = 1'b1;
        step();
        chk("bp_released", 32'(out_valid), 0);

        // throughput, with x0 writebacks running alongside
        f0 = fires;
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
        issue(5'd1, 5'd2, 5'd9, 1'b0);
        issue(5'd3, 5'd4, 5'd10, 1'b0);
        issue(5'd0, 5'd11, 5'd0, 1'b0);
        issue(5'd12, 5'd5, 5'd0, 1'b1);
        wb_en = 1'b0;
        step();
        chk("tput_fires", 32'(fires - f0), 4);
        chk("tput_idle", 32'(out_valid), 0);
        chk("x0_never_busy", busy_vec, 0);

        // reset while holding with x3 outstanding
        out_ready = 1'b0;
        issue(5'd1, 5'd2, 5'd3, 1'b1);
        step();
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_busy3", busy_vec, 32'h8);
        rst_n = 1'b0;
        step();
        sb.delete();
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_busy", busy_vec, 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        rst_n = 1'b1; out_ready = 1'b1;
        step();
        chk("midrst_stay_idle", 32'(out_valid), 0);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
